// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester line-to-byte RAM arbiter.
package apb_arb_pkg;

    localparam int unsigned BEATS          = 16;
    localparam int unsigned BEAT_W         = $clog2(BEATS);
    localparam int unsigned TIMEOUT_CYCLES = 15;

    typedef enum logic [1:0] {
        StIdle,
        StBeat,
        StResp
    } state_t;

    typedef logic owner_t;

endpackage

// File: rtl/apb_ram_arbiter_if.sv
// Requester line ports and byte-wide RAM port of the arbiter, grouped as one bundle.
interface apb_ram_arbiter_if #(
    parameter int unsigned addr_width = 4,
    parameter int unsigned data_width = 128,
    parameter int unsigned mem_data   = 8
);

    logic                    req0;
    logic                    req1;
    logic                    write0;
    logic                    write1;
    logic [addr_width-1:0]   line0;
    logic [addr_width-1:0]   line1;
    logic [data_width-1:0]   wdata0;
    logic [data_width-1:0]   wdata1;
    logic                    ack0;
    logic                    ack1;
    logic [data_width-1:0]   rsp_rdata;
    logic                    rsp_err;
    logic [addr_width+3:0]   m_addr;
    logic [mem_data-1:0]     m_wdata;
    logic                    m_write;
    logic                    m_cs;
    logic [mem_data-1:0]     m_rdata;
    logic                    m_ready;
    logic                    m_error;

    modport slave (
        input  req0, req1, write0, write1, line0, line1, wdata0, wdata1,
        output ack0, ack1, rsp_rdata, rsp_err,
        output m_addr, m_wdata, m_write, m_cs,
        input  m_rdata, m_ready, m_error
    );

    modport master (
        output req0, req1, write0, write1, line0, line1, wdata0, wdata1,
        input  ack0, ack1, rsp_rdata, rsp_err,
        input  m_addr, m_wdata, m_write, m_cs,
        output m_rdata, m_ready, m_error
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant; the last-served pointer moves when a response is issued.
module rr_arbiter2
    import apb_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req0,
    input  logic   req1,
    input  logic   update,
    input  owner_t served,
    output logic   valid,
    output owner_t grant
);

    owner_t last_q;

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= served;
        end
    end

    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            grant = ~last_q;
        end else begin
            grant = req1;
        end
    end

endmodule

// File: rtl/apb_ram_arbiter.sv
// Round-robin line arbiter sequencing 16 byte beats into a shared RAM.
// Optional macro ARB_TIMEOUT_EN aborts a transfer stalled on m_ready for TIMEOUT_CYCLES.
module apb_ram_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned addr_width = 4,
    parameter int unsigned data_width = 128,
    parameter int unsigned mem_data   = 8
) (
    input logic               PCLK,
    input logic               PRESET,
    apb_ram_arbiter_if.slave  bus
);

    state_t                  state_q, state_d;
    owner_t                  owner_q, owner_d;
    logic [addr_width-1:0]   line_q, line_d;
    logic                    write_q, write_d;
    logic [data_width-1:0]   wdata_q, wdata_d;
    logic [data_width-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic                    gnt_valid;
    owner_t                  gnt;
    logic                    in_beat;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0]       wait_q, wait_d;
`endif

    rr_arbiter2 u_rr (
        .clk    (PCLK),
        .rst    (PRESET),
        .req0   (bus.req0),
        .req1   (bus.req1),
        .update (state_q == StResp),
        .served (owner_q),
        .valid  (gnt_valid),
        .grant  (gnt)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            line_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            beat_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            line_q  <= line_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            beat_q  <= beat_d;
`ifdef ARB_TIMEOUT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        line_d  = line_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        beat_d  = beat_q;
`ifdef ARB_TIMEOUT_EN
        wait_d  = wait_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    owner_d = gnt;
                    line_d  = gnt ? bus.line1  : bus.line0;
                    write_d = gnt ? bus.write1 : bus.write0;
                    wdata_d = gnt ? bus.wdata1 : bus.wdata0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    beat_d  = '0;
`ifdef ARB_TIMEOUT_EN
                    wait_d  = '0;
`endif
                    state_d = StBeat;
                end
            end
            StBeat: begin
                if (bus.m_ready) begin
`ifdef ARB_TIMEOUT_EN
                    wait_d = '0;
`endif
                    if (!write_q) begin
                        rdata_d[int'(beat_q)*mem_data +: mem_data] = bus.m_rdata;
                    end
                    // An erroring beat ends the line early; unfetched bytes stay zero.
                    if (bus.m_error) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else if (beat_q == BEAT_W'(BEATS - 1)) begin
                        state_d = StResp;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign in_beat       = (state_q == StBeat);
    assign bus.ack0      = (state_q == StResp) && (owner_q == 1'b0);
    assign bus.ack1      = (state_q == StResp) && (owner_q == 1'b1);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.m_cs      = in_beat;
    assign bus.m_write   = in_beat && write_q;
    assign bus.m_addr    = {line_q, beat_q};
    assign bus.m_wdata   = wdata_q[int'(beat_q)*mem_data +: mem_data];

endmodule

// File: doc/apb_ram_arbiter.md
Name: apb_ram_arbiter

Overview:
- Shares the single byte-wide asynchronous RAM between two requesters, e.g. the APB slave controller and a DMA/scrub engine.
- Each request is a full 128-bit line transfer (write or read).
- The arbiter picks one requester round-robin and sequences 16 byte beats into the RAM.
- It assembles read bytes into a 128-bit response and returns one acknowledge pulse with error status.

Parameters:
- addr_width, 4: line index width.
- data_width, 128: requester line width.
- mem_data, 8: RAM data width. BEATS = data_width/mem_data = 16.
- TIMEOUT_CYCLES, 15: max consecutive cycles waiting on m_ready before abort. Used only with the optional feature.

Ports:
- PCLK  in  1  clock; all state updates on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- req0, req1  in  1 each  request; held high with stable payload until the matching ack.
- write0, write1  in  1 each  1 = write line, 0 = read line.
- line0, line1  in  addr_width each  line index.
- wdata0, wdata1  in  data_width each  write data; byte k = bits [8k+7:8k].
- ack0, ack1  out  1 each  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  data_width  read line; valid only in the ack cycle.
- rsp_err  out  1  error flag; valid only in the ack cycle.
- m_addr  out  addr_width+4  RAM byte address = {line_q, beat_q}.
- m_wdata  out  mem_data  byte beat_q of the latched wdata.
- m_write  out  1  RAM write enable.
- m_cs  out  1  RAM chip select.
- m_rdata  in  mem_data  RAM read data (combinational from the RAM).
- m_ready  in  1  RAM beat-accept.
- m_error  in  1  RAM beat error (e.g. address out of range).

Behaviour:
- FSM states: IDLE, BEAT, RESP.
- IDLE:
  - If any req is high: grant per round-robin, latch owner/line/write/wdata, clear rdata_q/err_q, set beat_q = 0, go to BEAT.
  - Only one requester asserted: it wins.
  - Both asserted: the requester not served last wins. The last-served pointer resets to 1, so requester 0 wins the first tie.
- BEAT:
  - m_cs = 1, m_write = write_q, m_addr = {line_q, beat_q}, m_wdata = wdata_q[8*beat_q +: 8].
  - A beat completes in a cycle where m_ready = 1. On completion, on a read, capture m_rdata into rdata_q byte beat_q.
  - If m_error = 1 on a completing beat: set err_q, abort the remaining beats, go to RESP.
  - Otherwise, after beat 15 go to RESP; else increment beat_q.
  - m_ready = 0 holds all outputs stable; the beat is retried the next cycle.
- RESP:
  - ack for the owner = 1 for exactly one cycle; rsp_rdata = rdata_q and rsp_err = err_q.
  - Update the last-served pointer to the owner, return to IDLE.
  - Bytes not fetched before an abort read as 0. On a write, rsp_rdata = 0.
- Latency, with m_ready always 1: req seen at edge N, beats on cycles N+1..N+16, ack on cycle N+17.
- A requester must drop req the cycle after its ack. A req still high in IDLE is treated as a new request.
- A request arriving during BEAT/RESP waits; requests are never dropped.
- Outside BEAT, m_cs = m_write = 0, and m_addr/m_wdata hold their last values.
- A write-line aborts partway on error; earlier bytes stay written, with no rollback.
- Reset outputs: ack0 = ack1 = 0, rsp_rdata = 0, rsp_err = 0, m_cs = m_write = 0, m_addr = 0, m_wdata = 0; state = IDLE, beat_q = 0.
- PRESET mid-transfer: immediate return to IDLE, m_cs drops asynchronously, no ack for the aborted transfer.
- Requesters must re-issue after reset.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A wait counter increments each BEAT cycle with m_ready = 0 and clears on any beat completion.
  - When the counter reaches TIMEOUT_CYCLES, set err_q, abort, go to RESP (ack with rsp_err = 1).
- Undefined: no counter; the arbiter waits on m_ready indefinitely.

Decomposition:
- Package apb_arb_pkg holds:
  - state enum (IDLE, BEAT, RESP)
  - BEATS constant and beat index width (log2 BEATS)
  - owner typedef (1 bit)
- Sub-module rr_arbiter2: 2-input round-robin grant from req0/req1 and the last-served pointer, with update on the RESP cycle. Everything else stays in the top.

Test Plan:
- req0 write line 0x3, wdata = 0x0F0E…0100, m_ready = 1 → m_addr 0x30..0x3F with bytes 0x00..0x0F; ack0 at N+17; rsp_err = 0.
- req1 read line 0x3 after the above → rsp_rdata = 0x0F0E…0100, ack1 only, 16 m_cs cycles.
- req0 and req1 asserted the same cycle twice in a row → first grant to 0, second to 1; no overlapping m_cs; each ack fires once.
- m_error = 1 on beat 5 of a read → 6 beats only, ack with rsp_err = 1, rsp_rdata bytes 6..15 = 0.
- PRESET pulsed at beat 8 → m_cs = 0 that cycle, no ack, next request starts at beat 0.
- ARB_TIMEOUT_EN with m_ready held 0 → ack with rsp_err = 1 after 15 wait cycles. Without the macro: no ack while m_ready = 0.
